// File: rtl/sd_pio_pkg.sv
// Shared constants for the SD-style bidirectional PIO: register addresses and edge-type encodings.
// Used by sd_pio_sync and sd_pio_bidir.
package sd_pio_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA    = 3'd0;
  localparam reg_addr_t ADDR_DIR     = 3'd1;
  localparam reg_addr_t ADDR_IRQMASK = 3'd2;
  localparam reg_addr_t ADDR_EDGECAP = 3'd3;
  localparam reg_addr_t ADDR_OUTSET  = 3'd4;
  localparam reg_addr_t ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sd_pio_sync.sv
// Pad input conditioning: two-flop synchroniser, a one-cycle history stage,
// and a per-bit edge pulse selected by EDGE_TYPE.
module sd_pio_sync
  import sd_pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  // prev resets to 0, so a pad high at reset release looks like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync_val = sync2;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_pulse = ~sync2 & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_pulse = sync2 ^ prev;
    end else begin : g_rise
      assign edge_pulse = sync2 & ~prev;
    end
  endgenerate

endmodule

// File: rtl/sd_pio_bidir.sv
// Avalon-MM bidirectional PIO for SD-style pad groups with edge capture and maskable irq.
// Define SD_PIO_OUTSETCLR_EN to add the atomic OUTSET/OUTCLEAR registers at addresses 4 and 5.
module sd_pio_bidir
  import sd_pio_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               EDGE_TYPE = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_next;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  sd_pio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pad        (bidir_port),
    .sync_val   (sync_val),
    .edge_pulse (edge_pulse)
  );

`ifdef SD_PIO_OUTSETCLR_EN
  assign set_mask = (wr_en && address == ADDR_OUTSET) ? wdata : '0;
  assign clr_mask = (wr_en && address == ADDR_OUTCLR) ? wdata : '0;
`else
  assign set_mask = '0;
  assign clr_mask = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg <= RESET_OUT;
    end else if (wr_en && address == ADDR_DATA) begin
      out_reg <= wdata;
    end else begin
      out_reg <= (out_reg | set_mask) & ~clr_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_reg  <= RESET_DIR;
      irq_mask <= '0;
    end else if (wr_en) begin
      if (address == ADDR_DIR) dir_reg <= wdata;
      if (address == ADDR_IRQMASK) irq_mask <= wdata;
    end
  end

  // A new edge in the same cycle as a write-1-clear keeps the bit set.
  assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = sync_val;
      ADDR_DIR:     rd_next[WIDTH-1:0] = dir_reg;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
      default:      rd_next = '0;
    endcase
  end

  // Read data is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_cap & irq_mask);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign bidir_port[i] = dir_reg[i] ? out_reg[i] : 1'bz;
    end
  endgenerate

endmodule

// File: tb/tb_sd_pio_bidir.sv
// Self-checking bench for sd_pio_bidir (WIDTH=4, rising edges, RESET_OUT=RESET_DIR=4'b0001).
// Honours SD_PIO_OUTSETCLR_EN when it is defined for the build.
module tb_sd_pio_bidir;
  import sd_pio_pkg::*;

  localparam int         TB_EDGE = EDGE_RISE;
  localparam logic [3:0] R_OUT   = 4'b0001;
  localparam logic [3:0] R_DIR   = 4'b0001;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  wire  [3:0]  pad;
  logic [3:0]  tb_drv     = 4'h0;
  logic [3:0]  tb_en;

  int errors = 0;
  int checks = 0;

  // Model state: registers plus the last three pad samples taken at clock edges.
  logic [3:0]  m_out  = R_OUT;
  logic [3:0]  m_dir  = R_DIR;
  logic [3:0]  m_mask = 4'h0;
  logic [3:0]  m_cap  = 4'h0;
  logic [3:0]  h0     = 4'h0;
  logic [3:0]  h1     = 4'h0;
  logic [3:0]  h2     = 4'h0;
  logic [31:0] m_rd   = 32'd0;
  logic        m_wr;

  assign m_wr  = chipselect & ~write_n;
  assign tb_en = ~m_dir;

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign pad[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  sd_pio_bidir #(
    .WIDTH     (4),
    .EDGE_TYPE (TB_EDGE),
    .RESET_OUT (R_OUT),
    .RESET_DIR (R_DIR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .bidir_port (pad),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pad_model();
    return (m_dir & m_out) | (~m_dir & tb_drv);
  endfunction

  function automatic logic [3:0] edges_of(logic [3:0] cur, logic [3:0] last);
    case (TB_EDGE)
      EDGE_FALL: return ~cur & last;
      EDGE_ANY:  return cur ^ last;
      default:   return cur & ~last;
    endcase
  endfunction

  // h1 is the pad value two edges back, which is what a DATA read returns.
  function automatic logic [31:0] read_model(logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      ADDR_DATA:    r[3:0] = h1;
      ADDR_DIR:     r[3:0] = m_dir;
      ADDR_IRQMASK: r[3:0] = m_mask;
      ADDR_EDGECAP: r[3:0] = m_cap;
      default:      r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out  <= R_OUT;
      m_dir  <= R_DIR;
      m_mask <= 4'h0;
      m_cap  <= 4'h0;
      h0     <= 4'h0;
      h1     <= 4'h0;
      h2     <= 4'h0;
      m_rd   <= 32'd0;
    end else begin
      m_rd  <= read_model(address);
      h0    <= pad_model();
      h1    <= h0;
      h2    <= h1;
      m_cap <= (m_cap & ~((m_wr && address == ADDR_EDGECAP) ? writedata[3:0] : 4'h0))
               | edges_of(h1, h2);
      if (m_wr) begin
        case (address)
          ADDR_DATA:    m_out  <= writedata[3:0];
          ADDR_DIR:     m_dir  <= writedata[3:0];
          ADDR_IRQMASK: m_mask <= writedata[3:0];
`ifdef SD_PIO_OUTSETCLR_EN
          ADDR_OUTSET:  m_out  <= m_out | writedata[3:0];
          ADDR_OUTCLR:  m_out  <= m_out & ~writedata[3:0];
`endif
          default: ;
        endcase
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("readdata", readdata, m_rd);
    check_output("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    check_output("pad", {28'd0, pad}, {28'd0, pad_model()});
  end

  // One bus cycle: inputs set just after a falling edge, sampled on the next rising edge.
  task automatic apply_stimulus(input logic [2:0] a, input logic wr, input logic [31:0] d);
    #1;
    address    = a;
    chipselect = wr;
    write_n    = ~wr;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_pad(input logic [3:0] v);
    #1;
    tb_drv = v;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_pad", {28'd0, pad}, 32'h1);
    check_output("rst_readdata", readdata, 32'h0);
    check_output("rst_irq", {31'd0, irq}, 32'h0);
    #1 reset_n = 1'b1;
    repeat (4) apply_stimulus(ADDR_DATA, 1'b0, 32'd0);

    apply_stimulus(ADDR_DIR, 1'b1, 32'hF);
    apply_stimulus(ADDR_DATA, 1'b1, 32'hFFFF_FFFA);
    check_output("drive_pad", {28'd0, pad}, 32'hA);
    repeat (3) apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    check_output("read_data", readdata, 32'hA);
    apply_stimulus(ADDR_DIR, 1'b0, 32'd0);
    check_output("read_dir", readdata, 32'hF);

    apply_stimulus(ADDR_DIR, 1'b1, 32'h0);
    apply_stimulus(ADDR_EDGECAP, 1'b1, 32'hF);
    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'h2);
    repeat (3) apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    check_output("cap_cleared", readdata, 32'h0);
    set_pad(4'b0010);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    check_output("irq_k", {31'd0, irq}, 32'h0);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    check_output("irq_k1", {31'd0, irq}, 32'h0);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    check_output("irq_k2", {31'd0, irq}, 32'h1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    check_output("cap_bit1", readdata, 32'h2);
    apply_stimulus(ADDR_EDGECAP, 1'b1, 32'h2);
    check_output("irq_w1c", {31'd0, irq}, 32'h0);

    set_pad(4'b0011);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    apply_stimulus(ADDR_EDGECAP, 1'b1, 32'h1);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    check_output("set_wins", readdata, 32'h1);

    apply_stimulus(ADDR_DIR, 1'b1, 32'hF);
    apply_stimulus(ADDR_DATA, 1'b1, 32'h5);
    check_output("out_5", {28'd0, pad}, 32'h5);
    apply_stimulus(ADDR_OUTSET, 1'b1, 32'h2);
`ifdef SD_PIO_OUTSETCLR_EN
    check_output("outset", {28'd0, pad}, 32'h7);
`else
    check_output("outset", {28'd0, pad}, 32'h5);
`endif
    apply_stimulus(ADDR_OUTCLR, 1'b1, 32'h4);
`ifdef SD_PIO_OUTSETCLR_EN
    check_output("outclr", {28'd0, pad}, 32'h3);
`else
    check_output("outclr", {28'd0, pad}, 32'h5);
`endif
    apply_stimulus(ADDR_OUTSET, 1'b0, 32'd0);
    check_output("read_outset", readdata, 32'h0);

    apply_stimulus(ADDR_IRQMASK, 1'b1, 32'hF);
    repeat (4) apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    set_pad(4'b0000);
    address    = ADDR_DATA;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'hC;
    #2 reset_n = 1'b0;
    #1;
    check_output("midrst_pad", {28'd0, pad}, 32'h1);
    check_output("midrst_readdata", readdata, 32'h0);
    check_output("midrst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    check_output("rel_cap", readdata, 32'h0);
    apply_stimulus(ADDR_IRQMASK, 1'b0, 32'd0);
    check_output("rel_mask", readdata, 32'h0);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    apply_stimulus(ADDR_EDGECAP, 1'b0, 32'd0);
    check_output("rel_edge", readdata, 32'h1);

    repeat (2) apply_stimulus(ADDR_DATA, 1'b0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
